timer_dev: RTL and testbench

TIMER_DEV -- requirements
Module: timer_dev

---
 rtl/timer_dev_if.sv | 26 ++
 rtl/timer_dev.sv | 107 ++++++++++
 tb/tb_timer_dev.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/timer_dev_if.sv
// timer_dev_if -- CPU register bus for the timer device.
//   addr   : register select (CPU address bits [3:2])
//   we     : write strobe, sampled at posedge clk
//   wdata  : write data
//   byteen : byte write enables (only when TIMER_BYTEEN_EN is defined)
//   rdata  : combinational read data from the device
//   irq    : registered interrupt request from the device
// Modports: master = CPU side, slave = timer side.
interface timer_dev_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
`ifdef TIMER_BYTEEN_EN
    logic [3:0]  byteen;
`endif
    logic [31:0] rdata;
    logic        irq;

`ifdef TIMER_BYTEEN_EN
    modport master (output addr, we, wdata, byteen, input rdata, irq);
    modport slave  (input addr, we, wdata, byteen, output rdata, irq);
`else
    modport master (output addr, we, wdata, input rdata, irq);
    modport slave  (input addr, we, wdata, output rdata, irq);
`endif
endinterface

// File: rtl/timer_dev.sv
// timer_dev -- 32-bit down-counting timer with one-shot / auto-reload modes.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : timer_dev_if.slave (addr, we, wdata, [byteen], rdata, irq)
// Register map: 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT (read-only), 3 reads 0.
// Optional feature: define TIMER_BYTEEN_EN to add per-byte write enables;
// a write with all byte enables low is then a complete no-op.
module timer_dev (
    input  logic       clk,
    input  logic       reset,
    timer_dev_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    logic        irq_q;

    logic [31:0] wmask;
    logic        wr_any;
    logic        wr_ctrl;
    logic        wr_preset;
    logic [3:0]  ctrl_nxt;
    logic [31:0] preset_nxt;

`ifdef TIMER_BYTEEN_EN
    for (genvar i = 0; i < 4; i++) begin : g_mask
        assign wmask[8*i +: 8] = {8{bus.byteen[i]}};
    end
`else
    assign wmask = '1;
`endif

    // An all-zero byte mask means the write never happened at all.
    assign wr_any     = bus.we && (wmask != 32'd0);
    assign wr_ctrl    = wr_any && (bus.addr == 2'd0);
    assign wr_preset  = wr_any && (bus.addr == 2'd1);
    assign ctrl_nxt   = wmask[0] ? bus.wdata[3:0] : ctrl;
    assign preset_nxt = (preset & ~wmask) | (bus.wdata & wmask);

    // irq_q is kept equal to irq_flag & IM by updating it alongside every
    // change of either, so irq comes straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
            irq_q    <= 1'b0;
        end else if (wr_ctrl || wr_preset) begin
            // CPU write wins over anything the FSM would do this edge.
            if (wr_ctrl)   ctrl   <= ctrl_nxt;
            if (wr_preset) preset <= preset_nxt;
            state    <= IDLE;
            irq_flag <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ctrl[0]) state <= LOAD;
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!ctrl[0]) begin
                        state <= IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count    <= 32'd0;
                        irq_flag <= 1'b1;
                        irq_q    <= ctrl[3];
                        state    <= INT;
                    end
                end
                INT: begin
                    if (ctrl[2:1] == 2'b01) begin
                        irq_flag <= 1'b0;
                        irq_q    <= 1'b0;
                        state    <= LOAD;
                    end else begin
                        ctrl[0] <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.rdata = 32'd0;
        case (bus.addr)
            2'd0:    bus.rdata = {28'd0, ctrl};
            2'd1:    bus.rdata = preset;
            2'd2:    bus.rdata = count;
            default: bus.rdata = 32'd0;
        endcase
    end

    assign bus.irq = irq_q;
endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev -- randomized scoreboard bench for timer_dev.
// The driver issues one bus cycle per clock and pushes the reference model's
// expected post-edge irq/rdata; a monitor pops and compares after each edge.
module tb_timer_dev;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    timer_dev_if bus();
    timer_dev dut (.clk(clk), .reset(reset), .bus(bus.slave));

    typedef struct {
        logic        irq;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model. phase: 0 waiting, 1 about to load, 2 counting, 3 expired.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    int          m_phase;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0; m_phase = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input bit w, input logic [1:0] a, input logic [31:0] d,
                              input logic [3:0] be);
        logic [3:0] be_eff;
`ifdef TIMER_BYTEEN_EN
        be_eff = be;
`else
        be_eff = be | 4'hF;  // no byte enables in this build: full word
`endif
        if (w && be_eff != 4'd0 && (a == 2'd0 || a == 2'd1)) begin
            if (a == 2'd0 && be_eff[0]) m_ctrl = d[3:0];
            if (a == 2'd1)
                for (int i = 0; i < 4; i++)
                    if (be_eff[i]) m_preset[8*i +: 8] = d[8*i +: 8];
            m_phase = 0;
            m_flag  = 1'b0;
        end else begin
            case (m_phase)
                0: if (m_ctrl[0]) m_phase = 1;
                1: begin m_count = m_preset; m_phase = 2; end
                2: begin
                    if (!m_ctrl[0]) m_phase = 0;
                    else if (m_count > 1) m_count = m_count - 1;
                    else begin m_count = 0; m_flag = 1'b1; m_phase = 3; end
                end
                default: begin
                    if (m_ctrl[2:1] == 2'b01) begin m_flag = 1'b0; m_phase = 1; end
                    else begin m_ctrl[0] = 1'b0; m_phase = 0; end
                end
            endcase
        end
    endtask

    task automatic cycle(input bit w, input logic [1:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        exp_t e;
        @(negedge clk);
        bus.we = w; bus.addr = a; bus.wdata = d;
`ifdef TIMER_BYTEEN_EN
        bus.byteen = be;
`endif
        model_edge(w, a, d, be);
        e.irq   = m_flag & m_ctrl[3];
        e.rdata = m_read(a);
        exp_q.push_back(e);
    endtask

    // Monitor: compares every edge for which the driver queued an expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("irq", {31'd0, bus.irq}, {31'd0, e.irq});
                check("rdata", bus.rdata, e.rdata);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int first;
        logic [1:0] a;
        int r;
        bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 32'd0;
`ifdef TIMER_BYTEEN_EN
        bus.byteen = 4'h0;
`endif
        model_reset();
        #3;
        for (int i = 0; i < 4; i++) begin
            bus.addr = 2'(i);
            #1 check("reset_rdata", bus.rdata, 32'd0);
        end
        check("reset_irq", {31'd0, bus.irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // One-shot, IM=1, PRESET=5: irq must first appear 7 edges after the CTRL write.
        cycle(1, 2'd1, 32'd5, 4'hF);
        cycle(1, 2'd0, 32'h9, 4'hF);
        first = -1;
        for (int k = 0; k < 20; k++) begin
            cycle(0, 2'd2, 32'd0, 4'hF);
            if (bus.irq && first < 0) first = k;
        end
        check("oneshot_irq_edge", first, 32'd7);
        cycle(0, 2'd0, 32'd0, 4'hF);

        // Auto-reload pulses, then masked one-shot.
        cycle(1, 2'd1, 32'd2, 4'hF);
        cycle(1, 2'd0, 32'hB, 4'hF);
        repeat (16) cycle(0, 2'd2, 32'd0, 4'hF);
        cycle(1, 2'd0, 32'h1, 4'hF);
        repeat (8) cycle(0, 2'd0, 32'd0, 4'hF);

        // Disable mid-count: COUNT must hold.
        cycle(1, 2'd1, 32'd10, 4'hF);
        cycle(1, 2'd0, 32'h9, 4'hF);
        repeat (6) cycle(0, 2'd2, 32'd0, 4'hF);
        cycle(1, 2'd0, 32'h8, 4'hF);
        repeat (4) cycle(0, 2'd2, 32'd0, 4'hF);

        // Maximum PRESET counts down without wrapping.
        cycle(1, 2'd1, 32'hFFFF_FFFF, 4'hF);
        cycle(1, 2'd0, 32'h1, 4'hF);
        repeat (6) cycle(0, 2'd2, 32'd0, 4'hF);

`ifdef TIMER_BYTEEN_EN
        cycle(1, 2'd1, 32'h1234_5678, 4'hF);
        cycle(1, 2'd1, 32'hAABB_CCDD, 4'b0011);
        cycle(0, 2'd1, 32'd0, 4'hF);
        check("byteen_merge", m_preset, 32'h1234_CCDD);
        cycle(1, 2'd0, 32'h9, 4'hF);
        cycle(0, 2'd2, 32'd0, 4'hF);
        cycle(1, 2'd1, 32'hFFFF_FFFF, 4'b0000);
        repeat (4) cycle(0, 2'd2, 32'd0, 4'hF);
`endif

        // Async reset mid-count.
        cycle(1, 2'd1, 32'd20, 4'hF);
        cycle(1, 2'd0, 32'h9, 4'hF);
        repeat (8) cycle(0, 2'd2, 32'd0, 4'hF);
        @(negedge clk);
        bus.we = 1'b0;
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.addr = 2'(i);
            #1 check("async_reset_rdata", bus.rdata, 32'd0);
        end
        check("async_reset_irq", {31'd0, bus.irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (5) cycle(0, 2'd2, 32'd0, 4'hF);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            logic [3:0] be;
            r  = int'($urandom_range(0, 99));
            be = 4'hF;
`ifdef TIMER_BYTEEN_EN
            if ($urandom_range(0, 3) == 0) be = 4'($urandom_range(0, 15));
`endif
            if (r < 8)
                cycle(1, 2'd0, {$urandom} & 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) | 32'h1, be);
            else if (r < 11)
                cycle(1, 2'd0, $urandom, be);
            else if (r < 18)
                cycle(1, 2'd1, 32'($urandom_range(0, 7)), be);
            else if (r < 22) begin
                a = 2'($urandom_range(2, 3));
                cycle(1, a, $urandom, be);
            end else begin
                a = 2'($urandom_range(0, 3));
                cycle(0, a, 32'd0, be);
            end
        end

        @(negedge clk);
        bus.we = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
